jtframe_mouse_acc: RTL and testbench
====================================

Name: jtframe_mouse_acc

Overview:
Multi-player mouse delta accumulator between the PS/2/USB mouse front-end and the game core. Sums signed mouse movement reports per player into saturating accumulators. The core collects them with a per-player read strobe that snapshots and clears atomically. Generalises per-report latching to N players, configurable width and scale, with no movement lost between core reads.

Parameters:
PLAYERS, 2, number of mouse channels (1..4)
ACCW, 8, accumulator/output width per axis, signed (4..16)
SHIFT, 1, arithmetic right shift applied to each incoming delta (0..4)
IDXW, 2, width of mouse_idx; must satisfy 2**IDXW >= PLAYERS

Ports:
clk  in  1  system clock
rst  in  1  reset
lock  in  1  high: incoming reports ignored
mouse_dx  in  9  signed X delta of the report
mouse_dy  in  9  signed Y delta of the report
mouse_f  in  8  button flags; bits [2:0] used
mouse_st  in  1  one-cycle report strobe
mouse_idx  in  IDXW  player index of the report
rd  in  PLAYERS  per-player read strobe from the core
pos_x  out  PLAYERS*ACCW  snapshot X per player, player p at [p*ACCW +: ACCW]
pos_y  out  PLAYERS*ACCW  snapshot Y, same packing
but  out  PLAYERS*3  latched buttons, player p at [p*3 +: 3]
pend  out  PLAYERS  movement accumulated since the last read

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk. On reset, accumulators, pos_x, pos_y, but and pend all go to 0.
- Report accept: mouse_st=1, lock=0 and mouse_idx < PLAYERS. Otherwise the report is dropped with no state change.
- Scaled delta: d = sign-extended (dx >>> SHIFT), same for dy. Arithmetic shift, so -1 >>> 1 = -1.
- Accumulate: acc <= sat(acc + d).
  - sum computed at ACCW+1 bits (or wider if 9-SHIFT > ACCW)
  - saturates to +2**(ACCW-1)-1 / -2**(ACCW-1); never wraps
  - d = 0 leaves pend unchanged; nonzero d sets pend
- Buttons: but[p] <= mouse_f[2:0] on every accepted report for p, whether or not it moves. Not affected by rd.
- Read: rd[p]=1 loads pos_x/pos_y[p] from acc[p] on the next edge. The same edge clears acc[p] and pend[p]. pos outputs hold until the next rd[p].
- Simultaneous report and rd for the same player, same cycle:
  - snapshot takes the pre-report acc
  - acc takes sat(0 + d)
  - pend is set iff d != 0
  - no movement is lost
- rd for several players in one cycle is legal; each is handled independently.
- Latency: report to acc is 1 cycle; rd to pos output is 1 cycle.
- lock high only blocks reports; rd still works.
- Reset mid-operation discards all accumulated motion.

Optional Feature:
JTFRAME_MOUSE_SIGNMAG_EN
- Defined: pos_x/pos_y are sign-magnitude. MSB is the sign; low ACCW-1 bits are |acc|.
  - negative full scale is clamped to magnitude 2**(ACCW-1)-1
  - zero is always all-zeros
- Undefined: two's complement.
- Conversion is applied at snapshot load; internal accumulators are always two's complement.

Decomposition:
Package jtframe_mouse_pkg holds:
- constant BUTW=3
- function sat_add(acc, d, width) returning the clamped sum
- function to_signmag

One sub-module, jtframe_mouse_axis: a single axis accumulator with snapshot/clear. It is instantiated 2*PLAYERS times via generate. Button latching and pend stay in the top level.

Test Plan:
- PLAYERS=2, ACCW=8, SHIFT=1: reports idx0 dx=+20 three times, then rd[0] -> pos_x[0]=30, pend[0] 1->0, player 1 outputs stay 0.
- dx=+255 (9-bit), SHIFT=0, ten reports then rd -> pos_x=127 saturated. Repeat with dx=-256 -> -128.
- Report dx=+8 and rd[1] in the same cycle for idx1 (prior acc=5, SHIFT=0) -> pos_x[1]=5, then after a second rd -> 8.
- lock=1 with reports dx=+50, and report with mouse_idx=3 when PLAYERS=2 -> acc, but, pend unchanged.
- Report dx=0, dy=0, f=3'b101 -> but[0]=101, pend[0] stays 0.
- With JTFRAME_MOUSE_SIGNMAG_EN and ACCW=8, acc=-5 then rd -> pos_x=8'h85. acc=-128 then rd -> 8'hFF. Assert rst mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/jtframe_mouse_pkg.sv
// -----------------------------------------------------------------------------
// jtframe_mouse_pkg
// Shared constants and arithmetic helpers for the mouse delta accumulator.
//   BUTW        : number of button flag bits latched per player
//   sat_add     : signed add clamped to a signed range of 'width' bits
//   to_signmag  : two's complement to sign-magnitude of 'width' bits, with
//                 negative full scale clamped to the largest magnitude
// Optional feature macro used by the users of this package:
//   JTFRAME_MOUSE_SIGNMAG_EN
// -----------------------------------------------------------------------------
package jtframe_mouse_pkg;

  localparam int BUTW = 3;

  // Operands are carried at 32 bits, which is wider than any legal
  // ACCW + 1, so the raw sum can never overflow before clamping.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] acc,
    input logic signed [31:0] d,
    input int                 width
  );
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = acc + d;
    hi  = (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
    lo  = -(32'sd1 <<< (width - 32'sd1));
    if (sum > hi) begin
      sat_add = hi;
    end else if (sum < lo) begin
      sat_add = lo;
    end else begin
      sat_add = sum;
    end
  endfunction

  // Zero maps to all-zeros because the sign bit is only set for v < 0.
  function automatic logic [31:0] to_signmag(
    input logic signed [31:0] v,
    input int                 width
  );
    logic signed [31:0] mag;
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
    if (v < 32'sd0) begin
      mag = -v;
    end else begin
      mag = v;
    end
    if (mag > hi) begin
      mag = hi;
    end else begin
      mag = mag;
    end
    if (v < 32'sd0) begin
      to_signmag = mag | (32'sd1 <<< (width - 32'sd1));
    end else begin
      to_signmag = mag;
    end
  endfunction

endpackage

// File: rtl/jtframe_mouse_acc_if.sv
// -----------------------------------------------------------------------------
// jtframe_mouse_acc_if
// Bundle between the mouse front-end / game core (master) and the
// accumulator (slave).
//   lock       : master->slave, ignore incoming reports while high
//   mouse_dx/dy: master->slave, 9-bit signed report deltas
//   mouse_f    : master->slave, button flags, bits [2:0] used
//   mouse_st   : master->slave, one-cycle report strobe
//   mouse_idx  : master->slave, player index of the report
//   rd         : master->slave, per-player snapshot-and-clear strobe
//   pos_x/pos_y: slave->master, per-player snapshots, player p at [p*ACCW +: ACCW]
//   but        : slave->master, latched buttons, player p at [p*3 +: 3]
//   pend       : slave->master, movement accumulated since last read
// Related macro: JTFRAME_MOUSE_SIGNMAG_EN (changes pos_x/pos_y encoding).
// -----------------------------------------------------------------------------
interface jtframe_mouse_acc_if
  import jtframe_mouse_pkg::*;
#(
  parameter int PLAYERS = 2,
  parameter int ACCW    = 8,
  parameter int IDXW    = 2
);
  logic                    lock;
  logic [8:0]              mouse_dx;
  logic [8:0]              mouse_dy;
  logic [7:0]              mouse_f;
  logic                    mouse_st;
  logic [IDXW-1:0]         mouse_idx;
  logic [PLAYERS-1:0]      rd;
  logic [PLAYERS*ACCW-1:0] pos_x;
  logic [PLAYERS*ACCW-1:0] pos_y;
  logic [PLAYERS*BUTW-1:0] but;
  logic [PLAYERS-1:0]      pend;

  modport master (
    output lock, mouse_dx, mouse_dy, mouse_f, mouse_st, mouse_idx, rd,
    input  pos_x, pos_y, but, pend
  );

  modport slave (
    input  lock, mouse_dx, mouse_dy, mouse_f, mouse_st, mouse_idx, rd,
    output pos_x, pos_y, but, pend
  );
endinterface

// File: rtl/jtframe_mouse_axis.sv
// -----------------------------------------------------------------------------
// jtframe_mouse_axis
// One saturating signed accumulator for a single axis of a single player,
// with an atomic snapshot-and-clear.
//   clk, rst : clock, asynchronous active-high reset
//   i_add    : accepted report for this player this cycle
//   i_d      : scaled signed delta (already shifted)
//   i_rd     : snapshot current accumulator and clear it
//   o_pos    : registered snapshot (two's complement, or sign-magnitude when
//              JTFRAME_MOUSE_SIGNMAG_EN is defined)
// -----------------------------------------------------------------------------
module jtframe_mouse_axis
  import jtframe_mouse_pkg::*;
#(
  parameter int ACCW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_add,
  input  logic signed [8:0] i_d,
  input  logic             i_rd,
  output logic [ACCW-1:0]  o_pos
);

  logic signed [ACCW-1:0] r_acc;
  logic [ACCW-1:0]        r_pos;
  logic signed [31:0]     w_acc32;
  logic signed [31:0]     w_d32;
  logic signed [31:0]     w_base;
  logic signed [ACCW-1:0] w_acc_nxt;
  logic [ACCW-1:0]        w_snap;

  // Next accumulator value and snapshot encoding
  always_comb begin
    w_acc32 = {{(32-ACCW){r_acc[ACCW-1]}}, r_acc};
    w_d32   = {{23{i_d[8]}}, i_d};
    // A read in the same cycle as a report restarts from zero, so the
    // report lands in the fresh accumulator instead of being lost.
    if (i_rd) begin
      w_base = 32'sd0;
    end else begin
      w_base = w_acc32;
    end
    if (i_add) begin
      w_acc_nxt = ACCW'(sat_add(w_base, w_d32, ACCW));
    end else if (i_rd) begin
      w_acc_nxt = '0;
    end else begin
      w_acc_nxt = r_acc;
    end
`ifdef JTFRAME_MOUSE_SIGNMAG_EN
    w_snap = ACCW'(to_signmag(w_acc32, ACCW));
`else
    w_snap = r_acc;
`endif
  end

  // Accumulator and snapshot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_pos <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      if (i_rd) begin
        r_pos <= w_snap;
      end
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/jtframe_mouse_acc.sv
// -----------------------------------------------------------------------------
// jtframe_mouse_acc
// Multi-player mouse delta accumulator. Reports from the mouse front-end are
// scaled by an arithmetic right shift and summed per player into saturating
// accumulators; the core collects each player with a read strobe that
// snapshots and clears atomically.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : jtframe_mouse_acc_if slave (reports, rd in; pos_x/pos_y/but/pend out)
// Parameters: PLAYERS (1..4), ACCW (4..16), SHIFT (0..4), IDXW (2**IDXW >= PLAYERS)
// Optional macro: JTFRAME_MOUSE_SIGNMAG_EN -> pos_x/pos_y in sign-magnitude.
// -----------------------------------------------------------------------------
module jtframe_mouse_acc
  import jtframe_mouse_pkg::*;
#(
  parameter int PLAYERS = 2,
  parameter int ACCW    = 8,
  parameter int SHIFT   = 1,
  parameter int IDXW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  jtframe_mouse_acc_if.slave bus
);

  logic signed [8:0]       w_dx;
  logic signed [8:0]       w_dy;
  logic                    w_move;
  logic [PLAYERS-1:0]      w_hit;
  logic [PLAYERS*BUTW-1:0] r_but;
  logic [PLAYERS-1:0]      r_pend;

  // Scaled deltas and per-player report acceptance
  always_comb begin
    w_dx   = $signed(bus.mouse_dx) >>> SHIFT;
    w_dy   = $signed(bus.mouse_dy) >>> SHIFT;
    w_move = (w_dx != 9'sd0) || (w_dy != 9'sd0);
    // Indices at or above PLAYERS match no channel, so they are dropped.
    for (int p = 0; p < PLAYERS; p++) begin
      w_hit[p] = bus.mouse_st & ~bus.lock & (bus.mouse_idx == IDXW'(p));
    end
  end

  // Button latches and pending-movement flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_but  <= '0;
      r_pend <= '0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (w_hit[p]) begin
          r_but[p*BUTW +: BUTW] <= bus.mouse_f[BUTW-1:0];
        end
        if (bus.rd[p]) begin
          r_pend[p] <= w_hit[p] & w_move;
        end else if (w_hit[p] & w_move) begin
          r_pend[p] <= 1'b1;
        end
      end
    end
  end

  assign bus.but  = r_but;
  assign bus.pend = r_pend;

  for (genvar gp = 0; gp < PLAYERS; gp++) begin : g_player
    jtframe_mouse_axis #(.ACCW(ACCW)) u_x (
      .clk   (clk),
      .rst   (rst),
      .i_add (w_hit[gp]),
      .i_d   (w_dx),
      .i_rd  (bus.rd[gp]),
      .o_pos (bus.pos_x[gp*ACCW +: ACCW])
    );
    jtframe_mouse_axis #(.ACCW(ACCW)) u_y (
      .clk   (clk),
      .rst   (rst),
      .i_add (w_hit[gp]),
      .i_d   (w_dy),
      .i_rd  (bus.rd[gp]),
      .o_pos (bus.pos_y[gp*ACCW +: ACCW])
    );
  end

endmodule

// File: tb/tb_jtframe_mouse_acc.sv
// -----------------------------------------------------------------------------
// tb_jtframe_mouse_acc
// Directed bench for jtframe_mouse_acc with PLAYERS=2, ACCW=8, SHIFT=1.
// Expected snapshot values are given for both encodings; the
// JTFRAME_MOUSE_SIGNMAG_EN macro selects which one applies.
// -----------------------------------------------------------------------------
module tb_jtframe_mouse_acc;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  jtframe_mouse_acc_if #(.PLAYERS(2), .ACCW(8), .IDXW(2)) bus ();

  jtframe_mouse_acc #(.PLAYERS(2), .ACCW(8), .SHIFT(1), .IDXW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [31:0] tc, input logic [31:0] sm);
`ifdef JTFRAME_MOUSE_SIGNMAG_EN
    return sm;
`else
    return tc;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] idx, input logic [8:0] dx,
                       input logic [8:0] dy, input logic [2:0] f, input logic [1:0] rdm);
    bus.mouse_st  = st;
    bus.mouse_idx = idx;
    bus.mouse_dx  = dx;
    bus.mouse_dy  = dy;
    bus.mouse_f   = {5'b11000, f};
    bus.rd        = rdm;
    tick();
    bus.mouse_st  = 1'b0;
    bus.mouse_dx  = 9'd0;
    bus.mouse_dy  = 9'd0;
    bus.rd        = 2'b00;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.lock = 1'b0;
    bus.mouse_st = 1'b0;
    bus.mouse_idx = 2'd0;
    bus.mouse_dx = 9'd0;
    bus.mouse_dy = 9'd0;
    bus.mouse_f = 8'd0;
    bus.rd = 2'b00;
    #12;
    chk("reset_pos_x", 32'(bus.pos_x), 32'h0);
    chk("reset_pos_y", 32'(bus.pos_y), 32'h0);
    chk("reset_but",   32'(bus.but),   32'h0);
    chk("reset_pend",  32'(bus.pend),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Three reports of +20/-6 for player 0: 10*3=30, -3*3=-9
    drive(1'b1, 2'd0, 9'd20, 9'h1FA, 3'b001, 2'b00);
    chk("pend_after_first", 32'(bus.pend), 32'h1);
    drive(1'b1, 2'd0, 9'd20, 9'h1FA, 3'b001, 2'b00);
    drive(1'b1, 2'd0, 9'd20, 9'h1FA, 3'b001, 2'b00);
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b01);
    chk("sum_pos_x0", 32'(bus.pos_x[7:0]), 32'h1E);
    chk("sum_pos_y0", 32'(bus.pos_y[7:0]), enc(32'hF7, 32'h89));
    chk("sum_pend",   32'(bus.pend), 32'h0);
    chk("sum_p1_x",   32'(bus.pos_x[15:8]), 32'h0);
    chk("sum_but",    32'(bus.but), 32'h01);

    // Second read with no reports returns the cleared accumulator
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b01);
    chk("clear_pos_x0", 32'(bus.pos_x[7:0]), 32'h0);

    // Saturation: +255 -> 127 and -256 -> -128 per report, ten reports
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd0, 9'h0FF, 9'h100, 3'b010, 2'b00);
    end
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b01);
    chk("sat_pos_x0", 32'(bus.pos_x[7:0]), 32'h7F);
    chk("sat_pos_y0", 32'(bus.pos_y[7:0]), enc(32'h80, 32'hFF));
    chk("sat_but",    32'(bus.but), 32'h02);

    // -1 >>> 1 stays -1, while +1 >>> 1 is 0
    drive(1'b1, 2'd0, 9'h1FF, 9'd1, 3'b001, 2'b00);
    chk("m1_pend", 32'(bus.pend), 32'h1);
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b01);
    chk("m1_pos_x0", 32'(bus.pos_x[7:0]), enc(32'hFF, 32'h81));
    chk("m1_pos_y0", 32'(bus.pos_y[7:0]), 32'h0);

    // -10 >>> 1 = -5
    drive(1'b1, 2'd0, 9'h1F6, 9'd0, 3'b001, 2'b00);
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b01);
    chk("m5_pos_x0", 32'(bus.pos_x[7:0]), enc(32'hFB, 32'h85));

    // Both players read in the same cycle
    drive(1'b1, 2'd0, 9'd6, 9'd0, 3'b001, 2'b00);
    drive(1'b1, 2'd1, 9'd0, 9'h1F8, 3'b100, 2'b00);
    chk("multi_pend", 32'(bus.pend), 32'h3);
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b11);
    chk("multi_pos_x0", 32'(bus.pos_x[7:0]), 32'h03);
    chk("multi_pos_y1", 32'(bus.pos_y[15:8]), enc(32'hFC, 32'h84));
    chk("multi_pend_clr", 32'(bus.pend), 32'h0);
    chk("multi_but", 32'(bus.but), 32'h21);

    // Report and read on player 1 in the same cycle
    drive(1'b1, 2'd1, 9'd10, 9'd0, 3'b100, 2'b00);
    chk("sim_pend_pre", 32'(bus.pend), 32'h2);
    drive(1'b1, 2'd1, 9'd16, 9'd0, 3'b100, 2'b10);
    chk("sim_pos_x1", 32'(bus.pos_x[15:8]), 32'h05);
    chk("sim_pend", 32'(bus.pend), 32'h2);
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b10);
    chk("sim_pos_x1_b", 32'(bus.pos_x[15:8]), 32'h08);
    chk("sim_pend_clr", 32'(bus.pend), 32'h0);

    // Zero-delta report together with read leaves pend clear
    drive(1'b1, 2'd1, 9'd4, 9'd0, 3'b100, 2'b00);
    drive(1'b1, 2'd1, 9'd0, 9'd0, 3'b100, 2'b10);
    chk("simz_pos_x1", 32'(bus.pos_x[15:8]), 32'h02);
    chk("simz_pend", 32'(bus.pend), 32'h0);

    // Locked reports are ignored but reads still work
    bus.lock = 1'b1;
    drive(1'b1, 2'd0, 9'd50, 9'd50, 3'b111, 2'b00);
    chk("lock_pend", 32'(bus.pend), 32'h0);
    chk("lock_but", 32'(bus.but), 32'h21);
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b01);
    chk("lock_rd_pos_x0", 32'(bus.pos_x[7:0]), 32'h0);
    bus.lock = 1'b0;

    // Out-of-range player index is ignored
    drive(1'b1, 2'd3, 9'd50, 9'd50, 3'b111, 2'b00);
    drive(1'b1, 2'd2, 9'd50, 9'd50, 3'b111, 2'b00);
    chk("idx_pend", 32'(bus.pend), 32'h0);
    chk("idx_but", 32'(bus.but), 32'h21);
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b11);
    chk("idx_pos_x", 32'(bus.pos_x), 32'h0);
    chk("idx_pos_y", 32'(bus.pos_y), 32'h0);

    // Zero-movement report only updates buttons
    drive(1'b1, 2'd0, 9'd0, 9'd0, 3'b101, 2'b00);
    chk("zero_but", 32'(bus.but), 32'h25);
    chk("zero_pend", 32'(bus.pend), 32'h0);

    // Build up state, then reset asynchronously mid-burst
    drive(1'b1, 2'd1, 9'd14, 9'd0, 3'b011, 2'b00);
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b10);
    chk("pre_rst_pos_x1", 32'(bus.pos_x[15:8]), 32'h07);
    drive(1'b1, 2'd0, 9'd40, 9'd40, 3'b110, 2'b00);
    chk("hold_pos_x1", 32'(bus.pos_x[15:8]), 32'h07);
    bus.mouse_st = 1'b1;
    bus.mouse_idx = 2'd0;
    bus.mouse_dx = 9'd40;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pos_x", 32'(bus.pos_x), 32'h0);
    chk("arst_pos_y", 32'(bus.pos_y), 32'h0);
    chk("arst_but",   32'(bus.but),   32'h0);
    chk("arst_pend",  32'(bus.pend),  32'h0);
    bus.mouse_st = 1'b0;
    bus.mouse_dx = 9'd0;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'd0, 9'd0, 9'd0, 3'b000, 2'b11);
    chk("post_rst_pos_x", 32'(bus.pos_x), 32'h0);
    chk("post_rst_pos_y", 32'(bus.pos_y), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
